activation_argmax: RTL
======================

Name: activation_argmax

Overview:
- Responder end of the start/done handshake used by the feedforward controller.
- Accepts a one-cycle start pulse and snapshots a flattened vector of N signed output-layer activations.
- Scans the vector sequentially and returns the index of the largest value as the predicted digit, with a one-cycle done pulse.
- Sits between the MLP output activations and the feedforward FSM; drop-in for the digit-prediction stage.

Parameters:
- WIDTH, 32, bit width of each activation; signed two's complement.
- N, 10, number of activations (output-layer neurons); legal range 2..16.
- IDX_W, 4, width of predicted index; must satisfy 2^IDX_W >= N.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- input_nums  input  N*WIDTH  flattened activations; element k at bits [k*WIDTH +: WIDTH].
- predicted_digit  output  IDX_W  index of maximum activation; registered.
- done  output  1  one-cycle completion pulse; registered.
- busy  output  1  high while a request is in progress (SCAN or DONE).

Behaviour:
- Reset: on any edge with reset=1, state goes to IDLE; predicted_digit=0, done=0, busy=0; internal snapshot, max and counter are cleared. Reset mid-scan aborts the request with no done pulse.
- States: IDLE, SCAN, DONE.
- IDLE, start=1 at edge t:
  - Copy input_nums into an internal snapshot register.
  - Set max_val=element0, max_idx=0, cnt=1; go to SCAN.
  - Later changes on input_nums do not affect the result.
- SCAN: at each edge, compare snapshot element cnt to max_val as signed values.
  - If strictly greater: max_val=element, max_idx=cnt.
  - Then cnt=cnt+1.
  - At the edge that compares element N-1 (edge t+N-1): load predicted_digit with the final max_idx, including that last comparison. Set done=1 and go to DONE.
- DONE: lasts one cycle. At the next edge done=0 and state goes to IDLE.
- Latency: done and the new predicted_digit both become visible after edge t+N-1, i.e. N-1 cycles after the start-sampling edge (9 for N=10). Throughput is one request per N+1 cycles.
- Ties: strict-greater compare, so the lowest index among equal maxima wins.
- Signed compare: 32'h8000_0000 is the minimum value; all-negative vectors are handled correctly.
- start while in SCAN or DONE is ignored (not queued). start high continuously re-triggers only from IDLE, so a new request is taken on the edge after DONE.
- predicted_digit holds its value between requests; it changes only at the done edge.
- busy=1 in SCAN and DONE, 0 in IDLE; registered, so it rises the cycle after start is sampled.
- cnt is IDX_W+1 bits wide and never wraps within a request. Unreachable state encodings go to IDLE.

Test Plan:
- Ascending vector element k = k*100 (N=10), start pulse at edge t -> done high exactly one cycle after edge t+9, predicted_digit=9, busy low one cycle after done.
- Ties: elements 3 and 7 = 500, others 10 -> predicted_digit=3. All ten equal -> predicted_digit=0.
- All negative: element k = -1000+k*(-5), except element 4 = -1 -> predicted_digit=4. Also element 0=32'h8000_0000 and the rest 32'h8000_0001 -> predicted_digit=1.
- Snapshot: start with max at index 2, then change input_nums to max at index 8 on the next cycle -> result=2. Second start pulse during SCAN -> ignored, exactly one done pulse.
- Reset mid-operation: assert reset at cycle t+4 for one cycle -> done never pulses, predicted_digit=0, busy=0. A following start then completes normally with the correct index.
- Back-to-back: hold start=1 for 30 cycles with a fixed vector (max at 6) -> done pulses every 11 cycles, predicted_digit=6 each time, no missed or extra pulses.

Source files
------------

// File: rtl/activation_argmax.sv
// activation_argmax: snapshots N signed activations on start, scans them one per cycle and reports the argmax with a done pulse.
module activation_argmax #(
  parameter int WIDTH = 32,
  parameter int N = 10,
  parameter int IDX_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N*WIDTH-1:0] input_nums,
  output logic [IDX_W-1:0]   predicted_digit,
  output logic               done,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, state_n;
  logic signed [WIDTH-1:0] snap [N];
  logic signed [WIDTH-1:0] max_val, max_val_n, elem;
  logic [IDX_W-1:0] max_idx, max_idx_n;
  logic [IDX_W:0] cnt;
  logic last, gt;
  always_comb begin
    elem = snap[cnt[IDX_W-1:0]];
    gt = elem > max_val;
    last = cnt == (IDX_W+1)'(N-1);
    max_val_n = gt ? elem : max_val;
    max_idx_n = gt ? cnt[IDX_W-1:0] : max_idx;
    state_n = (state == IDLE) ? (start ? SCAN : IDLE) :
              (state == SCAN) ? (last ? DONE : SCAN) : IDLE;
  end
  // cnt stops at N-1 on the final compare so the element select never leaves the array
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      predicted_digit <= '0;
      done <= 1'b0;
      busy <= 1'b0;
      max_val <= '0;
      max_idx <= '0;
      cnt <= '0;
      for (int k = 0; k < N; k++) snap[k] <= '0;
    end else begin
      state <= state_n;
      done <= state == SCAN && last;
      busy <= state_n != IDLE;
      if (state == IDLE && start) begin
        for (int k = 0; k < N; k++) snap[k] <= input_nums[k*WIDTH +: WIDTH];
        max_val <= input_nums[WIDTH-1:0];
        max_idx <= '0;
        cnt <= (IDX_W+1)'(1);
      end else if (state == SCAN) begin
        max_val <= max_val_n;
        max_idx <= max_idx_n;
        if (last) predicted_digit <= max_idx_n;
        else cnt <= cnt + 1'b1;
      end
    end
  end
endmodule
